// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   scan_state_t : scan FSM states (SHOW, BLANK)
//   SEG_BLANK    : active-low segment pattern with every segment off
//   clog2        : ceiling log2 for sizing counters from parameters
package display_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_bcdtosseg.sv
// Hex nibble to seven-segment decoder (common anode, active-low segments).
//   bcd : 4-bit digit value 0-F
//   seg : segments, bit 6 = a ... bit 0 = g; hex A-F shown as A b C d E F
module BCDtoSSeg (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (bcd)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode display.
//   clk, rst    : system clock (rising edge), asynchronous active-low reset
//   data_in     : nibble k drives digit k (digit 0 rightmost)
//   load        : strobe capturing data_in as the pending value
//   lz_en       : leading-zero blanking enable, sampled at each slot start
//   seg, an     : registered active-low segments / anodes
//   frame_tick  : one-cycle pulse after each frame boundary
//   upd_ack     : one-cycle pulse when a new value reaches the display
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic                  load,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick,
  output logic                  upd_ack
);

  localparam int unsigned CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = clog2(CNT_MAX);
  localparam int unsigned IDX_W   = (N_DIGITS > 1) ? clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  scan_state_t           state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [4*N_DIGITS-1:0] disp_reg, disp_n;
  logic [4*N_DIGITS-1:0] pend_reg, pend_n;
  logic                  pend_flag, pend_flag_n;
  logic                  boundary, ack_n;
  logic [6:0]            seg_n, dec_seg;
  logic [N_DIGITS-1:0]   an_n, onehot, nz_from;
  logic [3:0]            nib;
  logic                  nz_acc, lz_blank;

  // Scan sequencing and pending/display transfer
  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 1'b1;
    idx_n       = idx;
    boundary    = 1'b0;
    disp_n      = disp_reg;
    pend_n      = pend_reg;
    pend_flag_n = pend_flag;
    ack_n       = 1'b0;

    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_n  = SHOW;
          cnt_n    = '0;
          boundary = (idx == IDX_LAST);
          idx_n    = boundary ? '0 : idx + 1'b1;
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_n = BLANK;
          cnt_n   = '0;
        end
      end
      default: ;
    endcase

    if (load) begin
      pend_n      = data_in;
      pend_flag_n = 1'b1;
    end

    // A load landing on the boundary edge bypasses the pending register
    if (boundary) begin
      if (load) begin
        disp_n      = data_in;
        pend_flag_n = 1'b0;
        ack_n       = 1'b1;
      end else if (pend_flag) begin
        disp_n      = pend_reg;
        pend_flag_n = 1'b0;
        ack_n       = 1'b1;
      end
    end
  end

  // Decode from next-cycle index/value so seg and an register on the
  // same edge that enters SHOW, never showing a stale pair.
  always_comb begin
    nz_acc  = 1'b0;
    nz_from = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      nz_acc = nz_acc | (disp_n[4*(N_DIGITS-1-k) +: 4] != 4'h0);
      nz_from[N_DIGITS-1-k] = nz_acc;
    end
    nib      = disp_n[4*idx_n +: 4];
    lz_blank = lz_en && (idx_n != '0) && !nz_from[idx_n];
    onehot   = '0;
    onehot[idx_n] = 1'b1;

    seg_n = seg;
    an_n  = an;
    if (state_n == BLANK) begin
      seg_n = SEG_BLANK;
      an_n  = '1;
    end else if (state == BLANK) begin
      if (lz_blank) begin
        seg_n = SEG_BLANK;
        an_n  = '1;
      end else begin
        seg_n = dec_seg;
        an_n  = ~onehot;
      end
    end
  end

  BCDtoSSeg u_dec (
    .bcd (nib),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= IDX_LAST;
      disp_reg   <= '0;
      pend_reg   <= '0;
      pend_flag  <= 1'b0;
      seg        <= SEG_BLANK;
      an         <= '1;
      frame_tick <= 1'b0;
      upd_ack    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      disp_reg   <= disp_n;
      pend_reg   <= pend_n;
      pend_flag  <= pend_flag_n;
      seg        <= seg_n;
      an         <= an_n;
      frame_tick <= boundary;
      upd_ack    <= ack_n;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (N_DIGITS=4, CLK_DIV=4,
// BLANK_CYCLES=2, 24-cycle frame). Expected slot contents are queued at
// each frame boundary from the bench's own record of loads and popped as
// each slot is scanned.
module tb_display_scan_ctrl;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } slot_t;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic        load;
  logic        lz_en;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;
  logic        upd_ack;

  int n_tests = 0;
  int n_fail  = 0;

  int          k;
  logic [15:0] tb_pend = '0;
  int          ld_seq = 0;

  logic [15:0] tb_disp;
  int          seen_seq;
  int          pos;
  bit          bnd, bnd_ack;
  slot_t       e, cur;
  logic [3:0]  nib;
  slot_t       sb_q[$];

  display_scan_ctrl #(
    .N_DIGITS     (4),
    .CLK_DIV      (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load       (load),
    .lz_en      (lz_en),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick),
    .upd_ack    (upd_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Rising edges since reset release
  always @(posedge clk or negedge rst) begin
    if (!rst) k <= 0;
    else      k <= k + 1;
  end

  // Scoreboard producer (at boundaries) and consumer (every cycle)
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      tb_disp  = '0;
      seen_seq = ld_seq;
      sb_q.delete();
      cur = '{an: 4'hF, seg: 7'h7F};
    end else begin
      pos = k - 2;
      bnd = (k >= 2) && (pos % 24 == 0);
      if (bnd) begin
        bnd_ack = (seen_seq != ld_seq);
        if (bnd_ack) begin
          tb_disp  = tb_pend;
          seen_seq = ld_seq;
        end
        for (int d = 0; d < 4; d++) begin
          nib = tb_disp[4*d +: 4];
          e = '{an: 4'hF, seg: 7'h7F};
          if (!(lz_en && d > 0 && (tb_disp >> (4*d)) == 16'h0)) begin
            e.an  = ~(4'b0001 << d);
            e.seg = SEG_TBL[nib];
          end
          sb_q.push_back(e);
        end
      end
      check("frame_tick", frame_tick, bnd);
      check("upd_ack", upd_ack, bnd && bnd_ack);
      if (k < 2 || (pos % 6) >= 4) begin
        check("blank_an", an, 4'hF);
        check("blank_seg", seg, 7'h7F);
      end else begin
        if (pos % 6 == 0) begin
          check("sb_size", sb_q.size(), 4 - ((pos % 24) / 6));
          if (sb_q.size() != 0) cur = sb_q.pop_front();
        end
        check("slot_an", an, cur.an);
        check("slot_seg", seg, cur.seg);
      end
    end
  end

  // Returns 2 time units after the next rising edge with k % 24 == ph
  task automatic wait_phase(input int ph);
    bit hit;
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(posedge clk);
      #2;
      if (k % 24 == ph) hit = 1;
    end
    check("wait_phase", hit, 1'b1);
  endtask

  // Captured on the next rising edge; recorded once that edge has passed
  task automatic do_load(input logic [15:0] v);
    data_in = v;
    load    = 1'b1;
    @(posedge clk);
    #1;
    tb_pend = v;
    ld_seq++;
    load = 1'b0;
    #1;
  endtask

  initial begin
    rst     = 1'b0;
    data_in = '0;
    load    = 1'b0;
    lz_en   = 1'b0;

    // Reset values
    #12;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_tick", frame_tick, 1'b0);
    check("rst_ack", upd_ack, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;

    // Scan order with 1234, then tear-free update ABCD -> EF01
    wait_phase(13);
    do_load(16'h1234);
    wait_phase(9);
    wait_phase(9);
    do_load(16'hABCD);
    wait_phase(15);
    do_load(16'hEF01);
    wait_phase(13);
    wait_phase(13);

    // Leading-zero blanking
    do_load(16'h0050);
    wait_phase(1);
    lz_en = 1'b1;
    wait_phase(13);
    do_load(16'h0000);
    wait_phase(13);
    wait_phase(1);
    lz_en = 1'b0;
    wait_phase(13);

    // Load on the exact boundary edge
    wait_phase(1);
    do_load(16'h9876);
    wait_phase(13);
    wait_phase(13);

    // Asynchronous reset in the middle of a lit slot with data pending
    wait_phase(13);
    do_load(16'h5555);
    wait_phase(16);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_an", an, 4'hF);
    check("mid_rst_seg", seg, 7'h7F);
    check("mid_rst_tick", frame_tick, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    wait_phase(13);
    wait_phase(13);
    wait_phase(13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for an N-digit common-anode seven-segment display. It shares one BCD/hex-to-seven-segment decoder across all digits, stepping one digit per slot with a blanking gap between slots to suppress ghosting. Displayed values update only at frame boundaries, so a frame never mixes old and new digits. The block sits between the value-producing logic and the board's segment/anode pins.

## Interface
- N_DIGITS, 4: number of digits scanned. Legal range 1..8.
- CLK_DIV, 50000: clock cycles a digit stays lit per slot. Must be ≥ 2.
- BLANK_CYCLES, 8: cycles with all anodes off between slots. Must be ≥ 1.
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  4*N_DIGITS  nibble k drives digit k; digit 0 is rightmost (LSB).
- load  in  1  single-cycle strobe that captures data_in into the pending register.
- lz_en  in  1  leading-zero blanking enable, sampled each slot.
- seg  out  7  active-low segments: bit 6 = a … bit 0 = g.
- an  out  N_DIGITS  active-low anodes; bit k enables digit k.
- frame_tick  out  1  one-cycle pulse at each frame boundary.
- upd_ack  out  1  one-cycle pulse when pending data is transferred to the display register.

## Operation
- **Registers**
  - disp_reg: value currently shown.
  - pend_reg plus pend_flag: next value waiting for a frame boundary.
  - idx: current digit index.
  - cnt: slot counter.
  - state: one of SHOW or BLANK.
- **Load**
  - load=1 writes pend_reg ← data_in and sets pend_flag.
  - A later load in the same frame overwrites the earlier one (last wins).
- **BLANK state**
  - Drives an = all ones and seg = 7'h7F for BLANK_CYCLES cycles.
  - Then moves to SHOW with idx ← (idx == N_DIGITS-1) ? 0 : idx+1.
- **Frame boundary**
  - Defined as the BLANK→SHOW transition where idx wraps to 0. At that edge:
    - frame_tick = 1.
    - If pend_flag is set: disp_reg ← pend_reg, pend_flag ← 0, upd_ack = 1.
  - If load is also high on the boundary edge, data_in goes straight to disp_reg; it is shown this frame, upd_ack = 1, and pend_flag ends at 0.
- **SHOW state**
  - Lasts CLK_DIV cycles, then moves to BLANK.
  - seg = decoder(disp_reg nibble idx). Hex A–F is shown, not blanked.
  - an = ~(1 << idx), except when the digit is leading-blanked: then an = all ones and seg = 7'h7F.
- **Leading-zero blanking**
  - Applies when lz_en = 1, idx > 0, and every nibble from idx up to N_DIGITS-1 equals 0.
  - Digit 0 is never blanked.
- **Counter arithmetic**
  - cnt width = clog2(max(CLK_DIV, BLANK_CYCLES)).
  - cnt reloads to 0 on every state change and never overflows.

## Timing
- **Reset values**
  - an = all ones, seg = 7'h7F, frame_tick = 0, upd_ack = 0.
  - state = BLANK, idx = N_DIGITS-1, cnt = 0.
  - disp_reg = 0, pend_reg = 0, pend_flag = 0.
- **After reset release**
  - The first boundary occurs after BLANK_CYCLES cycles.
  - Digit 0 is then lit, showing 0 (or pending data if a load occurred).
- **Output registering**
  - seg and an are registered and update on the same edge as the state change; no cycle has a mismatched seg/an pair.
- **Periods**
  - Frame period = N_DIGITS × (CLK_DIV + BLANK_CYCLES) cycles.
  - Each digit is lit for exactly CLK_DIV consecutive cycles.
- **Reset mid-operation**
  - Outputs take their reset values immediately (asynchronous), and any pending data is discarded.

## Structure
- **Shared package** (display_pkg) holds:
  - The state encoding (SHOW, BLANK).
  - SEG_BLANK = 7'h7F.
  - A clog2 helper.
- **Sub-module**
  - The existing BCDtoSSeg decoder is instantiated once, driven by the nibble mux.
  - Its 7-bit output feeds the seg register.
- The prescaler and FSM stay in this module; no further hierarchy.

## Test plan
All scenarios use N_DIGITS=4, CLK_DIV=4, BLANK_CYCLES=2 (frame period 24 cycles).
- **Reset:** hold rst=0, then release; drive an/seg during reset and for the first 2 cycles → an=4'b1111, seg=7'h7F. Then digit 0 is lit with seg=7'b0000001, an=4'b1110.
- **Scan order:** load 16'h1234 before the boundary → per frame, 4 lit cycles for each digit, 2-cycle blank gaps, 24-cycle period:
  - an=1110 with seg=7'b1001100
  - an=1101 with seg=7'b0000110
  - an=1011 with seg=7'b0010010
  - an=0111 with seg=7'b1001111
- **Leading-zero blanking:**
  - lz_en=1 with 16'h0050 → digits 3 and 2 keep an=1111 during their slots; digits 1 and 0 show "5" and "0".
  - 16'h0000 → only digit 0 is lit.
  - lz_en=0 → all four digits are lit.
- **Tear-free update:** load 16'hABCD while digit 1 of 1234 is lit, then load 16'hEF01 → digits 2 and 3 still show 2 and 1. The next frame shows EF01; upd_ack pulses once, coincident with frame_tick.
- **Boundary collision:** load 16'h9876 on the exact boundary edge → digit 0 shows "6" (7'b0100000) in that same frame, upd_ack=1, no second upd_ack at the following boundary.
- **Reset mid-slot:** assert rst during a SHOW slot → an=1111 immediately, without waiting for a clock edge. After release the scan restarts as in the reset scenario, and previously pending data does not appear.
